// File: rtl/bench_seq_test_ctrl_if.sv
// Bundle between the test harness, the self-test controller and one
// benchmark instance.
//   start/golden        : harness -> controller run request and expected signature
//   busy/done/pass      : controller -> harness run status
//   signature           : controller -> harness current MISR value
//   dut_rst_n/dut_in    : controller -> benchmark reset and stimulus
//   dut_out             : benchmark -> controller response
//   abort               : harness -> controller, only with BENCH_SEQ_TEST_CTRL_ABORT_EN
// master = harness/benchmark side, slave = controller side.
interface bench_seq_test_ctrl_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
);
  logic             start;
  logic [15:0]      golden;
  logic             dut_rst_n;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      signature;
`ifdef BENCH_SEQ_TEST_CTRL_ABORT_EN
  logic             abort;

  modport master (output start, golden, dut_out, abort,
                  input  dut_rst_n, dut_in, busy, done, pass, signature);
  modport slave  (input  start, golden, dut_out, abort,
                  output dut_rst_n, dut_in, busy, done, pass, signature);
`else
  modport master (output start, golden, dut_out,
                  input  dut_rst_n, dut_in, busy, done, pass, signature);
  modport slave  (input  start, golden, dut_out,
                  output dut_rst_n, dut_in, busy, done, pass, signature);
`endif
endinterface

// File: rtl/bench_seq_test_ctrl.sv
// Self-test sequencer for one sequential benchmark instance.
// Holds the benchmark in reset, drives an LFSR stimulus stream for NUM_VEC
// cycles, compacts every response into a 16-bit MISR and compares the
// final signature against the golden value latched at start.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bench_seq_test_ctrl_if.slave (start, golden, busy, done, pass,
//           signature, dut_rst_n, dut_in, dut_out[, abort])
// Optional: define BENCH_SEQ_TEST_CTRL_ABORT_EN to add the abort input.
//
// state   | meaning
// IDLE    | benchmark held in reset, waiting for start
// RST_DUT | benchmark reset held for RST_CYC cycles
// APPLY   | LFSR vectors driven, MISR sampling responses
// FLUSH   | one extra MISR sample for the last vector's response
// COMPARE | signature compared against latched golden
// DONE    | result held, benchmark released, start accepted again
module bench_seq_test_ctrl #(
  parameter int          IN_W      = 3,
  parameter int          OUT_W     = 6,
  parameter int          NUM_VEC   = 64,
  parameter int          RST_CYC   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  bench_seq_test_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RST_DUT, APPLY, FLUSH, COMPARE, DONE} state_e;

  localparam int VEC_W = $clog2(NUM_VEC + 1);
  localparam int RST_W = $clog2(RST_CYC + 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // x^16+x^15+x^13+x^4+1, shared by the LFSR and the MISR.
  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       golden_q, golden_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       misr_q, misr_d;
  logic [VEC_W-1:0]  vcnt_q, vcnt_d;
  logic [RST_W-1:0]  rcnt_q, rcnt_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [OUT_W-1:0]  dout;
  logic [15:0]       misr_next;

  assign dout      = bus.dut_out;
  assign misr_next = poly_step(misr_q) ^ 16'(dout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      golden_q    <= '0;
      lfsr_q      <= SEED;
      misr_q      <= '0;
      vcnt_q      <= '0;
      rcnt_q      <= '0;
      dut_rst_n_q <= 1'b0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      golden_q    <= golden_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      vcnt_q      <= vcnt_d;
      rcnt_q      <= rcnt_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    golden_d = golden_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    vcnt_d   = vcnt_q;
    rcnt_d   = rcnt_q;
    dut_in_d = '0;
    done_d   = done_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RST_DUT;
          golden_d = bus.golden;
          lfsr_d   = SEED;
          misr_d   = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          rcnt_d   = RST_LAST;
        end
      end
      RST_DUT: begin
        if (rcnt_q == '0) begin
          // First vector goes out on the same edge that releases reset.
          state_d  = APPLY;
          vcnt_d   = VEC_LAST;
          dut_in_d = lfsr_q[IN_W-1:0];
          lfsr_d   = poly_step(lfsr_q);
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      APPLY: begin
        misr_d = misr_next;
        if (vcnt_q == '0) begin
          state_d = FLUSH;
        end else begin
          vcnt_d   = vcnt_q - 1'b1;
          dut_in_d = lfsr_q[IN_W-1:0];
          lfsr_d   = poly_step(lfsr_q);
        end
      end
      FLUSH: begin
        misr_d  = misr_next;
        state_d = COMPARE;
      end
      COMPARE: begin
        pass_d  = (misr_q == golden_q);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

`ifdef BENCH_SEQ_TEST_CTRL_ABORT_EN
    if (bus.abort && (state_q inside {RST_DUT, APPLY, FLUSH, COMPARE})) begin
      state_d  = IDLE;
      dut_in_d = '0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end
`endif

    // Registered outputs are decoded from the state being entered.
    busy_d      = state_d inside {RST_DUT, APPLY, FLUSH, COMPARE};
    dut_rst_n_d = state_d inside {APPLY, FLUSH, COMPARE, DONE};
  end

  assign bus.dut_rst_n = dut_rst_n_q;
  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;

endmodule

// File: doc/bench_seq_test_ctrl.md
Name: bench_seq_test_ctrl

Overview:
- Self-test sequencer for the generic sequential benchmark (3-bit input, 6-bit output, async active-low reset).
- Holds the benchmark in reset, then drives a pseudo-random 16-bit LFSR stimulus stream into it for a fixed number of cycles.
- Compacts every benchmark output sample into a 16-bit MISR and compares the final signature against a golden value.
- Provides pass/fail for trojan-detection runs; sits between the test harness and one benchmark instance.

Parameters:
- IN_W, 3: width of benchmark input bus dut_in.
- OUT_W, 6: width of benchmark output bus dut_out; must be ≤ 16.
- NUM_VEC, 64: stimulus cycles per run; must be ≥ 1.
- RST_CYC, 2: cycles dut_rst_n is held low at run start; must be ≥ 1.
- LFSR_SEED, 16'hACE1: LFSR load value; a seed of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- golden  in  16  expected signature; sampled when start is accepted.
- dut_rst_n  out  1  active-low reset to the benchmark.
- dut_in  out  IN_W  stimulus to the benchmark.
- dut_out  in  OUT_W  benchmark output.
- busy  out  1  run in progress.
- done  out  1  run complete; pass is valid.
- pass  out  1  1 = signature matched golden.
- signature  out  16  current MISR value.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, dut_rst_n=0, dut_in=0, busy=0, done=0, pass=0, signature=0, LFSR=seed, vector count=0.
- Asserting reset at any point, including mid-run, returns the block to these values immediately; there is no resume.
- States: IDLE, RST_DUT, APPLY, FLUSH, COMPARE, DONE.
- IDLE:
  - dut_rst_n=0.
  - start=1 -> RST_DUT; on the same edge latch golden, load the LFSR with the seed, clear the MISR, clear done and pass.
- RST_DUT:
  - dut_rst_n=0, dut_in=0, busy=1.
  - Stays RST_CYC cycles, then -> APPLY.
- APPLY:
  - dut_rst_n=1, busy=1.
  - dut_in = LFSR[IN_W-1:0].
  - LFSR steps every cycle.
  - MISR samples dut_out every cycle.
  - After NUM_VEC cycles -> FLUSH.
- FLUSH:
  - dut_in=0.
  - MISR samples dut_out once more, capturing the response to the last vector.
  - -> COMPARE.
- COMPARE:
  - pass <= (MISR == latched golden).
  - -> DONE.
- DONE:
  - busy=0, done=1.
  - pass and signature are held; dut_rst_n=1.
  - start=1 -> RST_DUT, with the same latching as in IDLE.
- LFSR: Fibonacci, polynomial x^16+x^15+x^13+x^4+1.
  - Next value = {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[12]^lfsr[3]}.
  - It never reaches 0.
- MISR: same feedback polynomial.
  - Next value = {misr[14:0], fb} XOR zero-extended dut_out.
- Latency: done rises RST_CYC+NUM_VEC+2 cycles after the edge that accepts start (68 with defaults).
- start while busy=1 is ignored, with no queuing.
- start and reset active together: reset wins.
- NUM_VEC=1: APPLY lasts exactly one cycle.
- The vector counter is $clog2(NUM_VEC+1) bits wide and never wraps within a run.

Optional Feature:
- Macro: BENCH_SEQ_TEST_CTRL_ABORT_EN.
- With the macro defined:
  - Extra input port abort (1 bit).
  - abort=1 in RST_DUT, APPLY, FLUSH or COMPARE forces IDLE on the next edge with dut_rst_n=0, dut_in=0, busy=0, done=0, pass=0.
  - abort has priority over start; abort in IDLE or DONE has no effect.
- Without the macro: no abort port; a run can only be stopped by reset.

Test Plan:
- Reset applied -> dut_rst_n=0, dut_in=0, busy=0, done=0, pass=0, signature=0.
- start with golden from the bench reference model (same LFSR/MISR driving a bench_seq model) -> busy=1 for 68 cycles, then done=1, pass=1, signature==golden.
- Same run with golden = model^16'h0001 -> done=1 at cycle 68, pass=0.
- start pulses during APPLY -> ignored: done still at cycle 68 of the first run, golden not re-latched.
- reset dropped at APPLY cycle 20 -> next cycle all outputs at reset values; a new start yields pass=1 again against the model.
- With ABORT_EN: abort at APPLY cycle 10 -> IDLE next cycle, busy=0, done=0, dut_rst_n=0; a following start completes normally.
